arb2_sel: RTL

ARB2_SEL -- requirements
Module: arb2_sel

---
 rtl/arb2_pkg.sv | 10 +
 rtl/arb2_beat_cnt.sv | 33 +++
 rtl/arb2_sel.sv | 122 ++++++++++++
 3 files changed

// File: rtl/arb2_pkg.sv
// Shared constants for the two-source grant arbiter.
// State encodings and mux select values used by arb2_sel.
package arb2_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_A = 2'd1;
    localparam logic [1:0] ST_GNT_B = 2'd2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/arb2_beat_cnt.sv
// Per-grant transfer counter: clear has priority, saturates at all-ones.
// Used by arb2_sel to report beats completed in the current grant.
module arb2_beat_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/arb2_sel.sv
// Two-source round-robin grant FSM driving a downstream 2:1 mux select.
// Define ARB2_BURST_LOCK_EN to hold a grant for up to BURST_MAX transfers.
module arb2_sel
    import arb2_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             ready,
    output logic             select,
    output logic             valid,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [CNT_W-1:0] beat_cnt
);
`ifdef ARB2_BURST_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic       select_q, select_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;

    logic       cur_req, oth_req, xfer;
    logic       burst_room, lock_stay;
    logic       cnt_clr, cnt_inc;
    logic [1:0] other_st;

    always_comb begin
        cur_req    = (state_q == ST_GNT_B) ? req_b : req_a;
        oth_req    = (state_q == ST_GNT_B) ? req_a : req_b;
        other_st   = (state_q == ST_GNT_B) ? ST_GNT_A : ST_GNT_B;
        valid      = ((state_q == ST_GNT_A) && req_a) ||
                     ((state_q == ST_GNT_B) && req_b);
        xfer       = valid && ready;
        burst_room = (int'(beat_cnt) + 1) < BURST_MAX;
        lock_stay  = LOCK_EN && cur_req && burst_room;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_a && req_b) begin
                    // Tie goes to whichever source was not served last
                    state_d = (last_q == SEL_B) ? ST_GNT_A : ST_GNT_B;
                end else if (req_a) begin
                    state_d = ST_GNT_A;
                end else if (req_b) begin
                    state_d = ST_GNT_B;
                end
            end
            ST_GNT_A, ST_GNT_B: begin
                if (xfer) begin
                    last_d = (state_q == ST_GNT_B) ? SEL_B : SEL_A;
                    if (lock_stay || (!oth_req && cur_req)) begin
                        cnt_inc = 1'b1;
                    end else if (oth_req) begin
                        state_d = other_st;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!cur_req) begin
                    state_d = oth_req ? other_st : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cnt_clr = (state_d != state_q);
    end

    always_comb begin
        select_d = select_q;
        if (state_d == ST_GNT_A) begin
            select_d = SEL_A;
        end else if (state_d == ST_GNT_B) begin
            select_d = SEL_B;
        end
        gnt_a_d = (state_d == ST_GNT_A);
        gnt_b_d = (state_d == ST_GNT_B);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            last_q   <= SEL_B;
            select_q <= SEL_A;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            select_q <= select_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
        end
    end

    arb2_beat_cnt #(
        .CNT_W (CNT_W)
    ) u_beat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (beat_cnt)
    );

    assign select = select_q;
    assign gnt_a  = gnt_a_q;
    assign gnt_b  = gnt_b_q;
endmodule
